// File: rtl/uart_pkg.sv
// Shared UART transmit-path types and frame constants.
// The serializer state enum and the default baud divisor live here so RX and TX agree.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200 baud
    localparam int FRAME_DATA_W         = 8;
    localparam int STOP_BITS            = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO feeding the TX serializer; rejects pushes while full, ignores pops while empty.
// Latency: a pushed word is visible at rd_data one edge later; backpressure is the full flag.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = FRAME_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO drained back-to-back by a serializer FSM.
// Latency: start bit one edge after the FIFO turns non-empty; writers back off on full (overflow is sticky).
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH        = 16,
    parameter int DATA_W       = FRAME_DATA_W
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     TX_Serial,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              baud_last;

    uart_tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk_100MHz),
        .rst_n   (reset),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign baud_last  = (baud_q == BAUD_LAST);
    assign TX_Serial  = tx_q;
    assign busy       = (state_q != IDLE);
    assign overflow   = overflow_q;
    assign overflow_d = overflow_q | (wr_en & full);

    // tx_d is the line level for the state being entered, so the line stays registered.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: scenario tasks compare line waveforms and decoded bytes
// against frames built from the 8N1 rules and queues of accepted bytes.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       TX_Serial;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       busy;
    logic       overflow;

    int compared   = 0;
    int mismatched = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .DATA_W       (8)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .TX_Serial  (TX_Serial),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    // Line waveform of one 8N1 frame: start 0, LSB-first payload, stop 1, each bit CPB samples.
    function automatic logic [399:0] add_frame(input logic [399:0] v, input int idx,
                                               input logic [7:0] b);
        logic [399:0] r;
        logic         lvl;
        r = v;
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      lvl = 1'b0;
            else if (j == 9) lvl = 1'b1;
            else             lvl = b[j-1];
            for (int c = 0; c < CPB; c++) r[idx*FRAME + j*CPB + c] = lvl;
        end
        return r;
    endfunction

    task automatic capture(input int n, output logic [399:0] v, output bit ok);
        int w;
        w  = 0;
        v  = '0;
        ok = 1'b0;
        do begin
            tick();
            w++;
        end while (TX_Serial !== 1'b0 && w < 300);
        if (TX_Serial !== 1'b0) return;
        ok = 1'b1;
        for (int s = 1; s < n; s++) begin
            tick();
            v[s] = TX_Serial;
        end
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int w;
        w  = 0;
        b  = '0;
        ok = 1'b0;
        while (TX_Serial !== 1'b0 && w < 300) begin
            tick();
            w++;
        end
        if (TX_Serial !== 1'b0) return;
        repeat (CPB/2) tick();
        if (TX_Serial !== 1'b0) return;
        for (int j = 0; j < 8; j++) begin
            repeat (CPB) tick();
            b[j] = TX_Serial;
        end
        repeat (CPB) tick();
        ok = (TX_Serial === 1'b1);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 100) begin
            tick();
            w++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; wr_data = '0;
        tick(); tick();
        compared++; if (TX_Serial !== 1'b1) begin mismatched++; $display("FAIL reset_tx: got %b want 1", TX_Serial); end
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty: got %b want 1", empty); end
        compared++; if (full !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %b want 0", full); end
        compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", count); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [399:0] obs, exp;
        logic         busy_first;
        exp = add_frame('0, 0, 8'hA5);
        obs = '0;
        busy_first = 1'b0;
        wr_data = 8'hA5; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        compared++; if (count !== 3'd1) begin mismatched++; $display("FAIL single_count_after_push: got %0d want 1", count); end
        compared++; if (TX_Serial !== 1'b1) begin mismatched++; $display("FAIL single_line_before_pop: got %b want 1", TX_Serial); end
        for (int s = 0; s < FRAME; s++) begin
            tick();
            obs[s] = TX_Serial;
            if (s == 0) busy_first = busy;
        end
        compared++; if (busy_first !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b want 1", busy_first); end
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL single_frame: got %h want %h", obs[FRAME-1:0], exp[FRAME-1:0]); end
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_end: got %b want 0", busy); end
        compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL single_count_end: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]   bytes [3];
        logic [399:0] obs, exp;
        bit           ok;
        bytes[0] = 8'h55; bytes[1] = 8'h0F; bytes[2] = 8'hFF;
        exp = '0;
        for (int i = 0; i < 3; i++) exp = add_frame(exp, i, bytes[i]);
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    wr_data = bytes[i]; wr_en = 1'b1;
                    tick();
                end
                wr_en = 1'b0;
            end
            capture(3*FRAME, obs, ok);
        join
        compared++; if (!ok) begin mismatched++; $display("FAIL b2b_start: got no start bit want start bit"); end
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL b2b_stream: got %h want %h", obs[3*FRAME-1:0], exp[3*FRAME-1:0]); end
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [7:0]   bytes [5];
        logic [399:0] obs, exp;
        bit           ok;
        for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
        exp = '0;
        for (int i = 0; i < 5; i++) exp = add_frame(exp, i, bytes[i]);
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    wr_data = bytes[i]; wr_en = 1'b1;
                    tick();
                end
                compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL ovf_count_full: got %0d want 4", count); end
                compared++; if (full !== 1'b1) begin mismatched++; $display("FAIL ovf_full: got %b want 1", full); end
                wr_data = 8'h99;
                tick();
                wr_en = 1'b0;
                compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag: got %b want 1", overflow); end
                compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL ovf_count_kept: got %0d want 4", count); end
            end
            capture(5*FRAME, obs, ok);
        join
        compared++; if (!ok) begin mismatched++; $display("FAIL ovf_start: got no start bit want start bit"); end
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL ovf_stream: got %h want %h", obs[5*FRAME-1:0], exp[5*FRAME-1:0]); end
        tick();
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL ovf_drained: got %b want 1", empty); end
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_push_on_pop();
        logic [7:0]   bytes [4];
        logic [399:0] obs, exp;
        bit           ok;
        for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
        exp = '0;
        for (int i = 0; i < 4; i++) exp = add_frame(exp, i, bytes[i]);
        fork
            begin
                // Edge 0 pushes the first byte; edge 41 is the last stop edge of its frame.
                for (int e = 0; e <= FRAME + 1; e++) begin
                    wr_en   = (e <= 2) || (e == FRAME + 1);
                    wr_data = (e <= 2) ? bytes[e] : bytes[3];
                    tick();
                    if (e == FRAME) begin
                        compared++; if (count !== 3'd2) begin mismatched++; $display("FAIL pp_count_before: got %0d want 2", count); end
                    end
                end
                wr_en = 1'b0;
                compared++; if (count !== 3'd2) begin mismatched++; $display("FAIL pp_count_same_edge: got %0d want 2", count); end
            end
            capture(4*FRAME, obs, ok);
        join
        compared++; if (!ok) begin mismatched++; $display("FAIL pp_start: got no start bit want start bit"); end
        compared++; if (obs !== exp) begin mismatched++; $display("FAIL pp_stream: got %h want %h", obs[4*FRAME-1:0], exp[4*FRAME-1:0]); end
        tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL pp_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        logic       line_b0, any_low, any_busy;
        b = 8'h3C;
        line_b0 = 1'b1;
        for (int e = 0; e < 3; e++) begin
            wr_en = 1'b1; wr_data = (e == 0) ? b : 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        // Edge 3 sample index after the start edge is (e-1); bit j spans 1+CPB*(1+j)..
        for (int e = 3; e <= 17; e++) begin
            tick();
            if (e == 1 + CPB + CPB/2) line_b0 = TX_Serial;
        end
        compared++; if (line_b0 !== b[0]) begin mismatched++; $display("FAIL rst_mid_bit0: got %b want %b", line_b0, b[0]); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL rst_mid_busy_before: got %b want 1", busy); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        compared++; if (TX_Serial !== 1'b1) begin mismatched++; $display("FAIL rst_mid_tx: got %b want 1", TX_Serial); end
        compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL rst_mid_count: got %0d want 0", count); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL rst_mid_empty: got %b want 1", empty); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
        any_low = 1'b0; any_busy = 1'b0;
        for (int i = 0; i < 2*FRAME; i++) begin
            tick();
            if (TX_Serial !== 1'b1) any_low = 1'b1;
            if (busy !== 1'b0) any_busy = 1'b1;
        end
        compared++; if (any_low !== 1'b0) begin mismatched++; $display("FAIL rst_mid_quiet_line: got activity want idle"); end
        compared++; if (any_busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_quiet_busy: got busy want idle"); end
    endtask

    task automatic test_wraparound();
        logic [7:0] got;
        bit         ok;
        for (int i = 0; i < 10; i++) begin
            fork
                begin
                    wr_data = 8'(i); wr_en = 1'b1;
                    tick();
                    wr_en = 1'b0;
                end
                recv_byte(got, ok);
            join
            compared++; if (!ok || got !== 8'(i)) begin mismatched++; $display("FAIL wrap_byte%0d: got %h ok=%0d want %h", i, got, ok, 8'(i)); end
            wait_idle();
        end
        compared++; if (busy !== 1'b0 || empty !== 1'b1) begin mismatched++; $display("FAIL wrap_idle: got busy=%b empty=%b want 0/1", busy, empty); end
    endtask

    task automatic test_random_bursts();
        logic [7:0] sent [$];
        logic [7:0] got  [$];
        for (int r = 0; r < 6; r++) begin
            int  n;
            bit  all_ok;
            n = $urandom_range(1, 5);
            sent.delete();
            got.delete();
            all_ok = 1'b1;
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        logic [7:0] v;
                        v = 8'($urandom);
                        sent.push_back(v);
                        wr_data = v; wr_en = 1'b1;
                        tick();
                        wr_en = 1'b0;
                        repeat ($urandom_range(0, 3)) tick();
                    end
                end
                begin
                    for (int j = 0; j < n; j++) begin
                        logic [7:0] b;
                        bit         ok;
                        recv_byte(b, ok);
                        if (!ok) all_ok = 1'b0;
                        got.push_back(b);
                    end
                end
            join
            compared++; if (!all_ok) begin mismatched++; $display("FAIL rand_framing_r%0d: got bad framing want clean frames", r); end
            for (int j = 0; j < n; j++) begin
                compared++; if (got[j] !== sent[j]) begin mismatched++; $display("FAIL rand_r%0d_b%0d: got %h want %h", r, j, got[j], sent[j]); end
            end
            wait_idle();
        end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rand_no_overflow: got %b want 0", overflow); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_on_pop();
        test_reset_mid_frame();
        test_wraparound();
        test_random_bursts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
